// File: rtl/instr_fetch_pkg.sv
// Shared decode-path definitions: instruction field positions,
// the R-type opcode and the fetch state encoding.
package proc_defs;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 3;
    localparam int FN_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus: request/address out,
// ack/read data back from memory.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_pc.sv
// Program counter: reset load, redirect load with word alignment,
// and +4 increment; reset beats redirect beats increment.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_en,
    input  logic              redir_en,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic [ADDR_W-1:0] pc
);

    // PC update with fixed priority; the add wraps modulo 2^ADDR_W
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redir_en) begin
            pc <= redir_pc & ~ADDR_W'(3);
        end else if (inc_en) begin
            pc <= pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: requests words from instruction memory, holds the
// instruction register under stall and honours branch redirects.
module instr_fetch
    import proc_defs::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [3:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic              is_rtype,
    output logic [ADDR_W-1:0] pc_out
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("instr_fetch: DATA_W must be 32");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("instr_fetch: RESET_PC must be word aligned");
    end

    logic [0:0]        state;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic              take;
    logic [6:0]        unused_ir;

    // A word is captured only on an ack in REQ not cancelled by a redirect
    assign take = (state == ST_REQ) && imem.imem_ack && !redirect_valid;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (take),
        .redir_en (redirect_valid),
        .redir_pc (redirect_pc),
        .pc       (pc)
    );

    assign imem.imem_req  = (state == ST_REQ) && !reset;
    assign imem.imem_addr = pc;

    assign opcode    = ir[OP_HI:OP_LO];
    assign rs        = ir[RS_HI:RS_LO];
    assign rt        = ir[RT_HI:RT_LO];
    assign rd        = ir[RD_HI:RD_LO];
    assign funct     = ir[FN_HI:FN_LO];
    assign is_rtype  = instr_valid && (opcode == OP_RTYPE);
    assign unused_ir = ir[RD_LO-1:FN_HI+1];

    // Fetch FSM and instruction register; redirect flushes from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_REQ;
            ir          <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (redirect_valid) begin
            state       <= ST_REQ;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        ir          <= imem.imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized
// traffic compared against a behavioural fetch model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [3:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_rtype;
    logic [7:0] pc_out;

    int checks = 0;
    int errors = 0;

    // behavioural model: PC, whether an instruction is held, IR, its address
    int          m_pc;
    bit          m_busy;
    logic [31:0] m_ir;
    int          m_pcout;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    instr_fetch #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .opcode         (opcode),
        .funct          (funct),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .is_rtype       (is_rtype),
        .pc_out         (pc_out)
    );

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc = 0; m_busy = 0; m_ir = 0; m_pcout = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc - (redirect_pc % 4);
            m_busy = 0;
        end else if (!m_busy) begin
            if (bus.imem_ack) begin
                m_ir = bus.imem_rdata;
                m_pcout = m_pc;
                m_pc = (m_pc + 4) % 256;
                m_busy = 1;
            end
        end else if (!stall) begin
            m_busy = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        bus.imem_ack = 0; bus.imem_rdata = 0;
        tick(); tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL rst_pc_out: got %h want 00", pc_out); end
        checks++; if (opcode !== 6'h00) begin errors++; $display("FAIL rst_ir: got %h want 00", opcode); end
        reset = 0; #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rel_addr: got %h want 00", bus.imem_addr); end
    endtask

    task automatic test_first_fetch();
        bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0801;
        tick();
        bus.imem_ack = 0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", instr_valid); end
        checks++; if (opcode !== 6'h00) begin errors++; $display("FAIL ff_opcode: got %h want 00", opcode); end
        checks++; if (funct !== 4'h1) begin errors++; $display("FAIL ff_funct: got %h want 1", funct); end
        checks++; if (rd !== 5'h01) begin errors++; $display("FAIL ff_rd: got %h want 01", rd); end
        checks++; if (is_rtype !== 1'b1) begin errors++; $display("FAIL ff_rtype: got %b want 1", is_rtype); end
        checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL ff_pc_out: got %h want 00", pc_out); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ff_hold_req: got %b want 0", bus.imem_req); end
        stall = 0;
        tick();
        checks++; if (bus.imem_addr !== 8'h04) begin errors++; $display("FAIL ff_next_addr: got %h want 04", bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_issue_valid: got %b want 0", instr_valid); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL ff_next_req: got %b want 1", bus.imem_req); end
    endtask

    task automatic test_ack_wait();
        for (int i = 0; i < 3; i++) begin
            bus.imem_rdata = $urandom;
            tick();
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, bus.imem_req); end
            checks++; if (bus.imem_addr !== 8'h04) begin errors++; $display("FAIL wait_addr[%0d]: got %h want 04", i, bus.imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
            checks++; if (funct !== 4'h1) begin errors++; $display("FAIL wait_ir[%0d]: got %h want 1", i, funct); end
        end
    endtask

    task automatic test_stall();
        bus.imem_ack = 1; bus.imem_rdata = 32'h0800_0000; stall = 1;
        tick();
        bus.imem_ack = 0; bus.imem_rdata = 32'hFFFF_FFFF;
        checks++; if (pc_out !== 8'h04) begin errors++; $display("FAIL st_pc_out: got %h want 04", pc_out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (opcode !== 6'b000010) begin errors++; $display("FAIL st_opcode[%0d]: got %h want 02", i, opcode); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d]: got %b want 1", i, instr_valid); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d]: got %b want 0", i, bus.imem_req); end
            checks++; if (is_rtype !== 1'b0) begin errors++; $display("FAIL st_rtype[%0d]: got %b want 0", i, is_rtype); end
        end
        stall = 0;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL st_issue: got %b want 0", instr_valid); end
        checks++; if (bus.imem_addr !== 8'h08) begin errors++; $display("FAIL st_next_addr: got %h want 08", bus.imem_addr); end
    endtask

    task automatic test_redirect_ack();
        bus.imem_ack = 1; bus.imem_rdata = 32'hFFFF_FFFF;
        redirect_valid = 1; redirect_pc = 8'h23;
        tick();
        bus.imem_ack = 0; redirect_valid = 0;
        checks++; if (opcode !== 6'b000010) begin errors++; $display("FAIL rd_ir: got %h want 02", opcode); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_valid: got %b want 0", instr_valid); end
        checks++; if (bus.imem_addr !== 8'h20) begin errors++; $display("FAIL rd_addr: got %h want 20", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rd_req: got %b want 1", bus.imem_req); end
        // redirect while stalled in HOLD still flushes
        bus.imem_ack = 1; bus.imem_rdata = 32'h1234_5678; stall = 1;
        tick();
        bus.imem_ack = 0; redirect_valid = 1; redirect_pc = 8'h41;
        tick();
        redirect_valid = 0; stall = 0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_hold_valid: got %b want 0", instr_valid); end
        checks++; if (bus.imem_addr !== 8'h40) begin errors++; $display("FAIL rd_hold_addr: got %h want 40", bus.imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1; redirect_pc = 8'hFC;
        tick();
        redirect_valid = 0; bus.imem_ack = 1; bus.imem_rdata = $urandom;
        tick();
        bus.imem_ack = 0;
        checks++; if (pc_out !== 8'hFC) begin errors++; $display("FAIL wrap_pc_out: got %h want fc", pc_out); end
        tick();
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h want 00", bus.imem_addr); end
    endtask

    task automatic test_reset_midwait();
        redirect_valid = 1; redirect_pc = 8'h30;
        tick();
        redirect_valid = 0; tick();
        bus.imem_ack = 1; bus.imem_rdata = 32'hA5A5_A5A5; reset = 1; #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mw_req: got %b want 0", bus.imem_req); end
        tick();
        bus.imem_ack = 0; reset = 0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mw_valid: got %b want 0", instr_valid); end
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mw_req_rel: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL mw_addr: got %h want 00", bus.imem_addr); end
        // reset beats a simultaneous redirect
        reset = 1; redirect_valid = 1; redirect_pc = 8'h40;
        tick();
        reset = 0; redirect_valid = 0;
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rst_vs_rd: got %h want 00", bus.imem_addr); end
    endtask

    task automatic test_random();
        bit exp_req;
        for (int i = 0; i < 400; i++) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            stall          = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 8'($urandom);
            reset          = ($urandom_range(0, 49) == 0);
            #1;
            exp_req = !m_busy && !reset;
            checks++; if (bus.imem_req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", i, bus.imem_req, exp_req); end
            tick();
            checks++; if (instr_valid !== m_busy) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, m_busy); end
            checks++; if (bus.imem_addr !== 8'(m_pc)) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, bus.imem_addr, 8'(m_pc)); end
            checks++; if (pc_out !== 8'(m_pcout)) begin errors++; $display("FAIL rnd_pc_out[%0d]: got %h want %h", i, pc_out, 8'(m_pcout)); end
            checks++; if (opcode !== 6'(m_ir >> 26)) begin errors++; $display("FAIL rnd_opcode[%0d]: got %h want %h", i, opcode, 6'(m_ir >> 26)); end
            checks++; if (rs !== 5'(m_ir >> 21)) begin errors++; $display("FAIL rnd_rs[%0d]: got %h want %h", i, rs, 5'(m_ir >> 21)); end
            checks++; if (rt !== 5'(m_ir >> 16)) begin errors++; $display("FAIL rnd_rt[%0d]: got %h want %h", i, rt, 5'(m_ir >> 16)); end
            checks++; if (rd !== 5'(m_ir >> 11)) begin errors++; $display("FAIL rnd_rd[%0d]: got %h want %h", i, rd, 5'(m_ir >> 11)); end
            checks++; if (funct !== 4'(m_ir)) begin errors++; $display("FAIL rnd_funct[%0d]: got %h want %h", i, funct, 4'(m_ir)); end
            checks++; if (is_rtype !== (m_busy && (m_ir >> 26) == 0)) begin errors++; $display("FAIL rnd_rtype[%0d]: got %b want %b", i, is_rtype, m_busy && (m_ir >> 26) == 0); end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_ack_wait();
        test_stall();
        test_redirect_ack();
        test_wrap();
        test_reset_midwait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
